// File: rtl/fpu_addsub_sched_if.sv
// Bundle between the add/sub scheduler, its two requesters and the shared add/sub unit.
// The master side is the requesters plus the shared unit; the slave side is the scheduler.
interface fpu_addsub_sched_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  req_mode;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic [31:0] au_a;
  logic [31:0] au_b;
  logic        au_mode;
  logic        au_zero_a;
  logic        au_zero_b;
  logic [31:0] au_result;
  logic        au_zero_sub;
  logic        busy;

  modport master (
    output req_valid, req_a, req_b, req_mode, rsp_ready, au_result, au_zero_sub,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, au_a, au_b, au_mode,
           au_zero_a, au_zero_b, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_mode, rsp_ready, au_result, au_zero_sub,
    output req_ready, rsp_valid, rsp_data, rsp_zero, au_a, au_b, au_mode,
           au_zero_a, au_zero_b, busy
  );
endinterface

// File: rtl/fpu_addsub_sched.sv
// Two-requester round-robin scheduler for a shared single-precision add/sub unit.
// Operands are latched on grant, the result is sampled after LAT busy cycles and held until accepted.
module fpu_addsub_sched #(
  parameter int unsigned LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  fpu_addsub_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  state_t      state_nx;
  logic        ptr;
  logic        gnt_q;
  logic        gnt_sel;
  logic        any_req;
  logic [3:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        mode_q;
  logic [31:0] rsp_data_q;
  logic        rsp_zero_q;

  assign any_req = |bus.req_valid;
  // The pointer only matters on contention; a lone requester always wins.
  assign gnt_sel = (&bus.req_valid) ? ptr : bus.req_valid[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = BUSY;
      BUSY:    if (cnt == 4'd1) state_nx = RESP;
      RESP:    if (bus.rsp_ready[gnt_q]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // req_ready is combinational, so it is gated by rst to stay low while reset is held.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.busy      = (state != IDLE);
    if (state == IDLE && any_req && !rst) bus.req_ready[gnt_sel] = 1'b1;
    if (state == RESP) bus.rsp_valid[gnt_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= 1'b0;
      gnt_q      <= 1'b0;
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= 1'b0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        gnt_q  <= gnt_sel;
        a_q    <= gnt_sel ? bus.req_a[63:32] : bus.req_a[31:0];
        b_q    <= gnt_sel ? bus.req_b[63:32] : bus.req_b[31:0];
        mode_q <= bus.req_mode[gnt_sel];
        cnt    <= 4'(LAT);
      end
      if (state == BUSY) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          rsp_data_q <= bus.au_result;
          rsp_zero_q <= bus.au_zero_sub;
        end
      end
      if (state == RESP && bus.rsp_ready[gnt_q]) ptr <= ~gnt_q;
    end
  end

  assign bus.au_a      = a_q;
  assign bus.au_b      = b_q;
  assign bus.au_mode   = mode_q;
  assign bus.au_zero_a = (a_q[30:0] == '0);
  assign bus.au_zero_b = (b_q[30:0] == '0);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
endmodule

// File: tb/tb_fpu_addsub_sched.sv
// Scoreboard bench for fpu_addsub_sched: grants and responses are predicted from the
// round-robin rules and compared by monitors that run independently of the stimulus.
module tb_fpu_addsub_sched;
  localparam int unsigned LAT = 3;

  logic clk = 1'b0;
  logic rst;
  fpu_addsub_sched_if bus ();

  fpu_addsub_sched #(.LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the shared unit: any deterministic function of the operands will do,
  // since the scheduler only routes and holds the result.
  function automatic logic [32:0] unit_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic m);
    logic [31:0] r;
    r = m ? (a - b) : (a + b);
    return {m && (a == b), r};
  endfunction

  assign {bus.au_zero_sub, bus.au_result} = unit_model(bus.au_a, bus.au_b, bus.au_mode);

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic        m;
    int          acc;
  } txn_t;

  txn_t sb[$];
  int   gnt_log[$];
  logic [1:0] seen_ready = 2'b00;
  logic ptr_m = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Accept monitor: predicts the grant from the valids and the round-robin pointer.
  always @(negedge clk) begin : acc_mon
    int g;
    logic [1:0] exp_ready;
    txn_t t;
    seen_ready = bus.req_ready;
    if (!rst) begin
      g = (&bus.req_valid) ? (ptr_m ? 1 : 0) : (bus.req_valid[1] ? 1 : 0);
      exp_ready = (sb.size() == 0 && bus.req_valid != 2'b00) ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
      check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      if (exp_ready != 2'b00) begin
        t.req = g;
        t.a   = (g == 1) ? bus.req_a[63:32] : bus.req_a[31:0];
        t.b   = (g == 1) ? bus.req_b[63:32] : bus.req_b[31:0];
        t.m   = bus.req_mode[g];
        t.acc = cyc;
        sb.push_back(t);
        gnt_log.push_back(g);
      end
    end
  end

  // Response monitor: pops the scoreboard on each completed response handshake.
  always @(negedge clk) begin : rsp_mon
    txn_t t;
    int el;
    logic [32:0] e;
    #1;
    if (rst) begin
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
      check("rst_rsp_zero", 64'(bus.rsp_zero), 64'(0));
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_req_ready", 64'(bus.req_ready), 64'(0));
      sb.delete();
      ptr_m = 1'b0;
    end else if (sb.size() == 0) begin
      check("idle_busy", 64'(bus.busy), 64'(0));
      check("idle_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    end else begin
      t  = sb[0];
      el = cyc - t.acc;
      e  = unit_model(t.a, t.b, t.m);
      check("busy", 64'(bus.busy), 64'(el >= 1));
      if (el >= 1) begin
        check("au_a", 64'(bus.au_a), 64'(t.a));
        check("au_b", 64'(bus.au_b), 64'(t.b));
        check("au_mode", 64'(bus.au_mode), 64'(t.m));
        check("au_zero_a", 64'(bus.au_zero_a), 64'(t.a[30:0] == 31'd0));
        check("au_zero_b", 64'(bus.au_zero_b), 64'(t.b[30:0] == 31'd0));
      end
      if (el >= int'(LAT) + 1) begin
        check("rsp_valid", 64'(bus.rsp_valid), 64'((t.req == 1) ? 2'b10 : 2'b01));
        check("rsp_data", 64'(bus.rsp_data), 64'(e[31:0]));
        check("rsp_zero", 64'(bus.rsp_zero), 64'(e[32]));
        if (bus.rsp_ready[t.req]) begin
          void'(sb.pop_front());
          ptr_m = (t.req == 0);
        end
      end else begin
        check("early_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      end
    end
  end

  logic [1:0]  hold;
  logic [31:0] a_h [2];
  logic [31:0] b_h [2];
  logic        m_h [2];

  task automatic drive();
    bus.req_valid = hold;
    bus.req_a     = {a_h[1], a_h[0]};
    bus.req_b     = {b_h[1], b_h[0]};
    bus.req_mode  = {m_h[1], m_h[0]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (seen_ready[i]) hold[i] = 1'b0;
  endtask

  task automatic new_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic m);
    hold[i] = 1'b1;
    a_h[i]  = a;
    b_h[i]  = b;
    m_h[i]  = m;
  endtask

  task automatic new_rand(input int i);
    logic [31:0] a;
    logic [31:0] b;
    logic m;
    a = $urandom;
    b = $urandom;
    m = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0: begin b = a; m = 1'b1; end
      1: a = {a[31], 31'd0};
      2: b = {b[31], 31'd0};
      default: ;
    endcase
    new_op(i, a, b, m);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    hold = 2'b00;
    bus.rsp_ready = 2'b11;
    drive();
    for (int k = 0; k < 80 && !done; k++) begin
      tick();
      drive();
      if (sb.size() == 0 && !bus.busy) done = 1;
    end
    check(name, 64'(done), 64'(1));
  endtask

  initial begin
    bit got;
    rst = 1'b1;
    hold = 2'b00;
    for (int i = 0; i < 2; i++) begin a_h[i] = '0; b_h[i] = '0; m_h[i] = 1'b0; end
    bus.rsp_ready = 2'b00;
    // Both requesters pending through reset: req_ready must stay low until release.
    new_op(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    new_op(1, 32'h40A0_0000, 32'h40A0_0000, 1'b1);
    drive();
    repeat (3) tick();
    rst = 1'b0;
    bus.rsp_ready = 2'b11;
    drive();

    // Continuous contention: grants must alternate 0,1,0,1.
    repeat (30) begin
      tick();
      for (int i = 0; i < 2; i++) if (!hold[i]) new_rand(i);
      drive();
    end
    check("alt_count_ge4", 64'(gnt_log.size() >= 4), 64'(1));
    for (int k = 0; k < 4 && k < gnt_log.size(); k++)
      check($sformatf("alt_grant_%0d", k), 64'(gnt_log[k]), 64'(k % 2));
    wait_idle("drain_alt");

    // Held response: data stable, no new grant while a request waits.
    bus.rsp_ready = 2'b00;
    tick();
    new_op(1, 32'h8000_0000, $urandom, 1'b0);
    drive();
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (!hold[1] && !hold[0]) new_rand(0);
      drive();
      if (bus.rsp_valid != 2'b00) got = 1;
    end
    check("stall_rsp_seen", 64'(got), 64'(1));
    repeat (5) begin tick(); drive(); end
    wait_idle("drain_stall");

    // Random traffic with dropped requests and random response back-pressure.
    repeat (1500) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (hold[i] && $urandom_range(0, 19) == 0) hold[i] = 1'b0;
        else if (!hold[i] && $urandom_range(0, 2) == 0) new_rand(i);
      end
      bus.rsp_ready = 2'($urandom_range(0, 3));
      drive();
    end
    wait_idle("drain_rand");

    // Leave the pointer at 1, then abort a transaction mid-BUSY with reset.
    tick();
    new_rand(0);
    drive();
    wait_idle("drain_pre_rst");
    tick();
    new_rand(1);
    drive();
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      drive();
      if (bus.busy) got = 1;
    end
    check("reached_busy", 64'(got), 64'(1));
    new_rand(0);
    drive();
    #1 rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'(0));
    check("async_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("async_rst_req_ready", 64'(bus.req_ready), 64'(0));
    gnt_log.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    new_rand(1);
    drive();
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      drive();
      if (gnt_log.size() > 0) got = 1;
    end
    check("post_rst_granted", 64'(got), 64'(1));
    if (got) check("post_rst_grant_req0", 64'(gnt_log[0]), 64'(0));
    wait_idle("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
